adder_pipe_ctrl: RTL

- Flow controller for the 4-stage, 8-bit-per-stage pipelined 32-bit adder (one-hot per-stage `stop`/`reset` controls).
- Registers operands from a valid/ready producer and tracks one valid bit per adder stage.
- Drives the adder's stop/reset codes to stall on output backpressure and to flush the pipeline.
- Presents sum and carry to a valid/ready consumer.

---
 rtl/adder_pipe_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/adder_pipe_ctrl.sv
// adder_pipe_ctrl: flow controller for a 4-stage, 8-bit-per-stage pipelined
// 32-bit adder.
// - Registers operands from a valid/ready producer.
// - Tracks one valid bit per adder stage.
// - Freezes the adder on output backpressure.
// - Flushes the adder stage by stage after reset or a flush pulse.
// Optional feature: define ADDER_PIPE_CTRL_PERF_EN to add the perf_ops and
// perf_stall saturating performance counters.
module adder_pipe_ctrl #(
    parameter int STAGES = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_a,
    input  logic [31:0]       in_b,
    input  logic              flush,
    output logic [31:0]       add_a,
    output logic [31:0]       add_b,
    output logic [STAGES-1:0] add_stop,
    output logic [STAGES-1:0] add_reset,
    input  logic [31:0]       add_sum,
    input  logic              add_c,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       sum_out,
    output logic              carry_out
`ifdef ADDER_PIPE_CTRL_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_ops,
    output logic [CNT_W-1:0]  perf_stall
`endif
);

    typedef enum logic [0:0] {RUN, FLUSH} state_t;

    state_t            state, state_next;
    logic [1:0]        fcnt;
    logic [STAGES:0]   v;
    logic              blocked;
    logic [STAGES-1:0] stop_all;
    logic [STAGES-1:0] reset_first;

    // The one-hot stop/reset codes and the 2-bit flush counter only make
    // sense for exactly four stages; reject anything else at elaboration.
    if (STAGES != 4 || CNT_W < 1) begin : g_bad_cfg
        $error("adder_pipe_ctrl supports only STAGES=4 and CNT_W>=1");
    end

    // Stopping the last stage freezes the whole adder. Partial stop codes are
    // useless here because stage 4 cannot be frozen on its own.
    assign stop_all    = {1'b1, {(STAGES-1){1'b0}}};
    assign reset_first = {{(STAGES-1){1'b0}}, 1'b1};
    assign blocked     = v[STAGES] & ~out_ready;

    // The result comes straight from the adder's last stage.
    assign sum_out   = add_sum;
    assign carry_out = add_c;

    // State register. Reset parks the controller in FLUSH, so the adder is
    // cleared before the first operand is accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= FLUSH;
        end else begin
            state <= state_next;
        end
    end

    // Next state and adder/handshake controls.
    // - A flush request does not mask in_ready; the operand offered in that
    //   cycle is simply dropped.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        add_stop   = '0;
        add_reset  = '0;
        case (state)
            RUN: begin
                out_valid = v[STAGES];
                if (blocked) begin
                    add_stop = stop_all;
                end else begin
                    in_ready = 1'b1;
                end
                if (flush) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                add_reset = reset_first << fcnt;
                if (fcnt == 2'd3) begin
                    state_next = RUN;
                end
            end
            default: state_next = FLUSH;
        endcase
    end

    // Flush counter, per-stage valid bits and operand registers.
    // - Everything holds while blocked, in step with the frozen adder.
    // - A flush has priority over both an accept and blocked.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fcnt  <= '0;
            v     <= '0;
            add_a <= '0;
            add_b <= '0;
        end else if (state == FLUSH) begin
            fcnt <= fcnt + 2'd1;
        end else if (flush) begin
            fcnt  <= '0;
            v     <= '0;
            add_a <= '0;
            add_b <= '0;
        end else if (!blocked) begin
            v <= {v[STAGES-1:0], in_valid};
            if (in_valid) begin
                add_a <= in_a;
                add_b <= in_b;
            end
        end
    end

`ifdef ADDER_PIPE_CTRL_PERF_EN
    // Saturating counters of output transfers and of stalled RUN cycles.
    // A flush does not clear them.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            perf_ops   <= '0;
            perf_stall <= '0;
        end else begin
            if (out_valid && out_ready && perf_ops != '1) begin
                perf_ops <= perf_ops + CNT_W'(1);
            end
            if (state == RUN && blocked && perf_stall != '1) begin
                perf_stall <= perf_stall + CNT_W'(1);
            end
        end
    end
`endif

endmodule
